// File: rtl/conv3x3_pkg.sv
// Shared types and constants for the conv3x3_stream engine.
package conv3x3_pkg;

  // Kernel selection, latched once per frame
  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_GAUSS  = 2'd1,
    MODE_SHARP  = 2'd2,
    MODE_LAPL   = 2'd3
  } mode_e;

  // Input-to-output pipeline depth in clock cycles
  localparam int unsigned CONV_LAT = 4;

  // Signed accumulator width: covers 16*max (gaussian) and 5*max (sharpen)
  function automatic int unsigned ACC_W(input int unsigned data_w);
    return data_w + 5;
  endfunction

endpackage

// File: rtl/conv3x3_linebuf.sv
// Ping-pong two-row line buffer with read-before-write and vertical border
// handling. Build option CONV3X3_BORDER_ZERO_EN selects zero padding for rows
// above the image instead of replicating row 0.
module conv3x3_linebuf
  import conv3x3_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned X_W    = 9,
  parameter int unsigned Y_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              sof,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [DATA_W-1:0] pixel,
  output logic [DATA_W-1:0] top_c,
  output logic [DATA_W-1:0] mid_c,
  output logic [DATA_W-1:0] cur_c
);

  logic [DATA_W-1:0] ram0 [IMG_W];
  logic [DATA_W-1:0] ram1 [IMG_W];
  logic              sel_q;
  logic              row_sel_c;
  logic [DATA_W-1:0] old_row_c;
  logic [DATA_W-1:0] prev_row_c;

  // Buffer owned by the current row: flips at each line start, row 0 always uses buffer 0
  always_comb begin
    row_sel_c = sel_q;
    if (x == '0) row_sel_c = sof ? 1'b0 : ~sel_q;
  end

  // Remember which buffer the current row is filling
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
    end else if (wr_en && x == '0) begin
      sel_q <= row_sel_c;
    end
  end

  // Overwrite the row y-2 buffer with row y (old contents are read first)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (row_sel_c) ram1[x] <= pixel;
      else           ram0[x] <= pixel;
    end
  end

  // Read the two stored rows and apply the vertical border rule
  always_comb begin
    old_row_c  = row_sel_c ? ram1[x] : ram0[x];
    prev_row_c = row_sel_c ? ram0[x] : ram1[x];
    cur_c      = pixel;
`ifdef CONV3X3_BORDER_ZERO_EN
    mid_c = (y == '0) ? '0 : prev_row_c;
    top_c = (y <= Y_W'(1)) ? '0 : old_row_c;
`else
    mid_c = (y == '0) ? pixel : prev_row_c;
    top_c = (y == '0) ? pixel : ((y == Y_W'(1)) ? prev_row_c : old_row_c);
`endif
  end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution (bypass / gaussian / sharpen / laplacian) with a
// fixed 4-cycle latency and coordinate passthrough. Build option
// CONV3X3_BORDER_ZERO_EN reads out-of-image taps as 0 instead of clamping.
module conv3x3_stream
  import conv3x3_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned X_W    = 9,
  parameter int unsigned Y_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [X_W-1:0]    in_x,
  input  logic [Y_W-1:0]    in_y,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic [1:0]        mode,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pixel,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y
);

  localparam int unsigned AW   = ACC_W(DATA_W);
  localparam int unsigned PS_W = DATA_W + 2;

  mode_e             mode_q, mode_in_c;
  logic              frame_act_q;
  logic              take_c;
  logic [CONV_LAT-2:0] vld_q;

  logic [DATA_W-1:0] top_tap, mid_tap, cur_tap;
  logic [DATA_W-1:0] tap_c [3];
  logic [DATA_W-1:0] win_c [3][3];
  logic [DATA_W-1:0] w_q   [3][3];

  logic [X_W-1:0]    s1_x, s2_x, s3_x;
  logic [Y_W-1:0]    s1_y, s2_y, s3_y;
  mode_e             s1_mode, s2_mode, s3_mode;
  logic [DATA_W-1:0] s2_c;
  logic [PS_W-1:0]   s2_e, s2_k;
  logic signed [AW-1:0] c_s, e_s, k_s, sum_c, s3_acc;
  logic [AW-1:0]     mag_c;
  logic [DATA_W-1:0] res_c;

  // Pixels are accepted only inside a frame that started after reset
  assign take_c    = in_valid & (frame_act_q | in_sof);
  assign mode_in_c = (in_valid && in_sof) ? mode_e'(mode) : mode_q;

  conv3x3_linebuf #(
    .DATA_W(DATA_W),
    .IMG_W (IMG_W),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_linebuf (
    .clk  (clk),
    .rst_n(rst_n),
    .wr_en(take_c),
    .sof  (in_sof),
    .x    (in_x),
    .y    (in_y),
    .pixel(in_pixel),
    .top_c(top_tap),
    .mid_c(mid_tap),
    .cur_c(cur_tap)
  );

  // Column taps from the line buffer, rows y-2, y-1, y
  always_comb begin
    tap_c[0] = top_tap;
    tap_c[1] = mid_tap;
    tap_c[2] = cur_tap;
  end

  // Assemble columns x-2..x from the shift registers with horizontal border rule
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_c[r][2] = tap_c[r];
`ifdef CONV3X3_BORDER_ZERO_EN
      win_c[r][1] = (in_x == '0) ? '0 : w_q[r][2];
      win_c[r][0] = (in_x <= X_W'(1)) ? '0 : w_q[r][1];
`else
      win_c[r][1] = (in_x == '0) ? tap_c[r] : w_q[r][2];
      win_c[r][0] = (in_x == '0) ? tap_c[r] :
                    ((in_x == X_W'(1)) ? w_q[r][2] : w_q[r][1]);
`endif
    end
  end

  // Control state: frame tracking, per-frame mode latch, valid pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_act_q <= 1'b0;
      mode_q      <= MODE_GAUSS;
      vld_q       <= '0;
    end else begin
      vld_q <= {vld_q[CONV_LAT-3:0], take_c};
      if (in_valid && in_sof) begin
        frame_act_q <= 1'b1;
        mode_q      <= mode_e'(mode);
      end
    end
  end

  // S1: window capture; the window registers double as horizontal shift registers
  always_ff @(posedge clk) begin
    if (take_c) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          w_q[r][c] <= win_c[r][c];
        end
      end
      s1_x    <= in_x;
      s1_y    <= in_y;
      s1_mode <= mode_in_c;
    end
  end

  // S2: centre, edge and corner partial sums
  always_ff @(posedge clk) begin
    s2_c    <= w_q[1][1];
    s2_e    <= PS_W'(w_q[0][1]) + PS_W'(w_q[1][0]) + PS_W'(w_q[1][2]) + PS_W'(w_q[2][1]);
    s2_k    <= PS_W'(w_q[0][0]) + PS_W'(w_q[0][2]) + PS_W'(w_q[2][0]) + PS_W'(w_q[2][2]);
    s2_x    <= s1_x;
    s2_y    <= s1_y;
    s2_mode <= s1_mode;
  end

  // Kernel-weighted signed sum
  always_comb begin
    c_s   = $signed(AW'(s2_c));
    e_s   = $signed(AW'(s2_e));
    k_s   = $signed(AW'(s2_k));
    sum_c = c_s;
    case (s2_mode)
      MODE_GAUSS: sum_c = k_s + (e_s <<< 1) + (c_s <<< 2);
      MODE_SHARP: sum_c = (c_s <<< 2) + c_s - e_s;
      MODE_LAPL:  sum_c = (c_s <<< 2) - e_s;
      default:    sum_c = c_s;
    endcase
  end

  // S3: accumulator register
  always_ff @(posedge clk) begin
    s3_acc  <= sum_c;
    s3_x    <= s2_x;
    s3_y    <= s2_y;
    s3_mode <= s2_mode;
  end

  // Normalise (gaussian), clamp (sharpen) or rectify and saturate (laplacian)
  always_comb begin
    mag_c = s3_acc[AW-1] ? AW'(-s3_acc) : AW'(s3_acc);
    res_c = s3_acc[DATA_W-1:0];
    case (s3_mode)
      MODE_GAUSS: res_c = s3_acc[DATA_W+3:4];
      MODE_SHARP: begin
        if (s3_acc[AW-1])              res_c = '0;
        else if (|s3_acc[AW-2:DATA_W]) res_c = '1;
      end
      MODE_LAPL: begin
        if (|mag_c[AW-1:DATA_W]) res_c = '1;
        else                     res_c = mag_c[DATA_W-1:0];
      end
      default: res_c = s3_acc[DATA_W-1:0];
    endcase
  end

  // S4: output register; coordinates hold across bubbles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= vld_q[CONV_LAT-2];
      out_pixel <= vld_q[CONV_LAT-2] ? res_c : '0;
      if (vld_q[CONV_LAT-2]) begin
        out_x <= s3_x;
        out_y <= s3_y;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 16x12 frame.
module tb_conv3x3_stream;
  import conv3x3_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 16;
  localparam int unsigned H  = 12;
  localparam int unsigned XW = 4;
  localparam int unsigned YW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_sof;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic [DW-1:0] in_pixel;
  logic [1:0]    mode;
  logic          out_valid;
  logic [DW-1:0] out_pixel;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int lat_bad = 0;
  bit lat_en = 1'b0;
  logic [CONV_LAT-1:0] vh = '0;
  int res [H][W];
  int outq[$];
  int refq[$];

  always #5 clk = ~clk;

  conv3x3_stream #(
    .DATA_W(DW),
    .IMG_W (W),
    .X_W   (XW),
    .Y_W   (YW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_pixel (in_pixel),
    .mode     (mode),
    .out_valid(out_valid),
    .out_pixel(out_pixel),
    .out_x    (out_x),
    .out_y    (out_y)
  );

  // Output capture and latency tracking on the falling edge
  always @(negedge clk) begin
    if (out_valid) begin
      n_out++;
      if (int'(out_y) < H && int'(out_x) < W) res[int'(out_y)][int'(out_x)] = int'(out_pixel);
      outq.push_back(int'(out_pixel) | (int'(out_x) << 8) | (int'(out_y) << 16));
    end
    if (lat_en && out_valid !== vh[CONV_LAT-1]) lat_bad++;
    vh = {vh[CONV_LAT-2:0], in_valid};
  end

  function automatic int pix(input int pat, input int x, input int y);
    case (pat)
      0:       return 100;
      1:       return (x == 5 && y == 5) ? 255 : 0;
      2:       return (x == 5 && y == 5) ? 0 : 255;
      3:       return 200;
      4:       return (x >= 10) ? 255 : 0;
      default: return 4 * x + 8 * y;
    endcase
  endfunction

  // Tags whose window touches the left/top border differ between border builds
  function automatic bit border_ok(input int tx, input int ty);
`ifdef CONV3X3_BORDER_ZERO_EN
    return (tx >= 2 && ty >= 2);
`else
    return (tx >= 0 && ty >= 0);
`endif
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_pix(input int pat, input int x, input int y, input bit sof, input logic [1:0] m);
    in_valid = 1'b1;
    in_sof   = sof;
    in_x     = XW'(x);
    in_y     = YW'(y);
    in_pixel = DW'(pix(pat, x, y));
    mode     = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drive_frame(input int pat, input bit gaps, input logic [1:0] m0,
                             input logic [1:0] m1, input int sw_row);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (gaps) while ($urandom_range(1) == 0) idle(1);
        put_pix(pat, x, y, (x == 0 && y == 0), (y >= sw_row) ? m1 : m0);
      end
    end
    idle(10);
  endtask

  task automatic clear_res();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) res[y][x] = -1;
    outq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    in_x = '0; in_y = '0; in_pixel = '0; mode = 2'd1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (out_pixel !== '0) begin bad++; $display("FAIL reset_pixel got=%0d want=0", out_pixel); end
    total++; if (out_x !== '0) begin bad++; $display("FAIL reset_x got=%0d want=0", out_x); end
    total++; if (out_y !== '0) begin bad++; $display("FAIL reset_y got=%0d want=0", out_y); end
  endtask

  task automatic test_flat_gauss();
    int n0, lb;
    clear_res(); n0 = n_out; lb = lat_bad; lat_en = 1'b1;
    drive_frame(0, 1'b0, 2'd1, 2'd1, H);
    total++; if (n_out - n0 !== W * H) begin bad++; $display("FAIL flat_count got=%0d want=%0d", n_out - n0, W * H); end
    total++; if (lat_bad !== lb) begin bad++; $display("FAIL flat_latency got=%0d want=%0d", lat_bad, lb); end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (border_ok(x, y)) begin
          total++;
          if (res[y][x] !== 100) begin bad++; $display("FAIL flat_gauss(%0d,%0d) got=%0d want=100", x, y, res[y][x]); end
        end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%0b want=0", out_valid); end
    total++; if (out_pixel !== '0) begin bad++; $display("FAIL idle_pixel got=%0d want=0", out_pixel); end
    total++; if (out_x !== XW'(W - 1)) begin bad++; $display("FAIL idle_x_hold got=%0d want=%0d", out_x, W - 1); end
    total++; if (out_y !== YW'(H - 1)) begin bad++; $display("FAIL idle_y_hold got=%0d want=%0d", out_y, H - 1); end
  endtask

  task automatic test_impulse_gauss();
    int dx, dy, e;
    clear_res();
    drive_frame(1, 1'b0, 2'd1, 2'd1, H);
    for (int ty = 0; ty < H; ty++)
      for (int tx = 0; tx < W; tx++) begin
        dx = tx - 6; dy = ty - 6; e = 0;
        if (dx >= -1 && dx <= 1 && dy >= -1 && dy <= 1)
          e = (255 * ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1)) >> 4;
        total++;
        if (res[ty][tx] !== e) begin bad++; $display("FAIL impulse_gauss(%0d,%0d) got=%0d want=%0d", tx, ty, res[ty][tx], e); end
      end
  endtask

  task automatic test_sharpen();
    int e;
    clear_res();
    drive_frame(1, 1'b0, 2'd2, 2'd2, H);
    for (int ty = 0; ty < H; ty++)
      for (int tx = 0; tx < W; tx++) begin
        e = (tx == 6 && ty == 6) ? 255 : 0;
        total++;
        if (res[ty][tx] !== e) begin bad++; $display("FAIL sharp_hi(%0d,%0d) got=%0d want=%0d", tx, ty, res[ty][tx], e); end
      end
    clear_res();
    drive_frame(2, 1'b0, 2'd2, 2'd2, H);
    for (int ty = 0; ty < H; ty++)
      for (int tx = 0; tx < W; tx++)
        if (border_ok(tx, ty)) begin
          e = (tx == 6 && ty == 6) ? 0 : 255;
          total++;
          if (res[ty][tx] !== e) begin bad++; $display("FAIL sharp_lo(%0d,%0d) got=%0d want=%0d", tx, ty, res[ty][tx], e); end
        end
  endtask

  task automatic test_laplacian();
    int e;
    clear_res();
    drive_frame(3, 1'b0, 2'd3, 2'd3, H);
    for (int ty = 0; ty < H; ty++)
      for (int tx = 0; tx < W; tx++)
        if (border_ok(tx, ty)) begin
          total++;
          if (res[ty][tx] !== 0) begin bad++; $display("FAIL lapl_flat(%0d,%0d) got=%0d want=0", tx, ty, res[ty][tx]); end
        end
    clear_res();
    drive_frame(4, 1'b0, 2'd3, 2'd3, H);
    for (int ty = 0; ty < H; ty++)
      for (int tx = 0; tx < W; tx++)
        if (border_ok(tx, ty)) begin
          e = (tx == 10 || tx == 11) ? 255 : 0;
          total++;
          if (res[ty][tx] !== e) begin bad++; $display("FAIL lapl_step(%0d,%0d) got=%0d want=%0d", tx, ty, res[ty][tx], e); end
        end
  endtask

  task automatic test_mode_switch();
    clear_res();
    drive_frame(1, 1'b0, 2'd1, 2'd2, 3);
    total++; if (res[6][6] !== 63) begin bad++; $display("FAIL sw_gauss_66 got=%0d want=63", res[6][6]); end
    total++; if (res[5][6] !== 31) begin bad++; $display("FAIL sw_gauss_65 got=%0d want=31", res[5][6]); end
    total++; if (res[7][7] !== 15) begin bad++; $display("FAIL sw_gauss_77 got=%0d want=15", res[7][7]); end
    clear_res();
    drive_frame(1, 1'b0, 2'd2, 2'd2, H);
    total++; if (res[6][6] !== 255) begin bad++; $display("FAIL sw_sharp_66 got=%0d want=255", res[6][6]); end
    total++; if (res[5][6] !== 0) begin bad++; $display("FAIL sw_sharp_65 got=%0d want=0", res[5][6]); end
    total++; if (res[7][7] !== 0) begin bad++; $display("FAIL sw_sharp_77 got=%0d want=0", res[7][7]); end
  endtask

  task automatic test_reset_midline();
    int n0, lb;
    lat_en = 1'b0;
    clear_res();
    for (int i = 0; i < 2 * W + 8; i++) put_pix(0, i % W, i / W, (i == 0), 2'd1);
    rst_n = 1'b0;
    put_pix(0, 8, 2, 1'b0, 2'd1);
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", out_valid); end
    n0 = n_out;
    for (int i = 2 * W + 9; i < W * H; i++) put_pix(0, i % W, i / W, 1'b0, 2'd1);
    idle(10);
    total++; if (n_out - n0 !== 0) begin bad++; $display("FAIL midrst_quiet got=%0d want=0", n_out - n0); end
    lat_en = 1'b1;
    clear_res(); n0 = n_out; lb = lat_bad;
    drive_frame(0, 1'b0, 2'd1, 2'd1, H);
    total++; if (n_out - n0 !== W * H) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", n_out - n0, W * H); end
    total++; if (lat_bad !== lb) begin bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat_bad, lb); end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (border_ok(x, y)) begin
          total++;
          if (res[y][x] !== 100) begin bad++; $display("FAIL midrst_pix(%0d,%0d) got=%0d want=100", x, y, res[y][x]); end
        end
  endtask

  task automatic test_gaps();
    int lb, e;
    clear_res();
    drive_frame(5, 1'b0, 2'd1, 2'd1, H);
    refq = outq;
    clear_res(); lb = lat_bad;
    drive_frame(5, 1'b1, 2'd1, 2'd1, H);
    total++; if (outq.size() !== refq.size()) begin bad++; $display("FAIL gap_count got=%0d want=%0d", outq.size(), refq.size()); end
    total++; if (lat_bad !== lb) begin bad++; $display("FAIL gap_latency got=%0d want=%0d", lat_bad, lb); end
    for (int i = 0; i < refq.size() && i < outq.size(); i++) begin
      total++;
      if (outq[i] !== refq[i]) begin bad++; $display("FAIL gap_seq[%0d] got=%0h want=%0h", i, outq[i], refq[i]); end
    end
    for (int ty = 2; ty < H; ty++)
      for (int tx = 2; tx < W; tx++) begin
        e = 4 * (tx - 1) + 8 * (ty - 1);
        total++;
        if (res[ty][tx] !== e) begin bad++; $display("FAIL gap_ramp(%0d,%0d) got=%0d want=%0d", tx, ty, res[ty][tx], e); end
      end
  endtask

  initial begin
    test_reset();
    test_flat_gauss();
    test_impulse_gauss();
    test_sharpen();
    test_laplacian();
    test_mode_switch();
    test_reset_midline();
    test_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Parametrised streaming 3x3 convolution engine for grayscale video.
- Selectable kernel per frame: bypass, Gaussian blur, sharpen, Laplacian edge.
- Sits between the camera gray converter and the frame-buffer write path.
- Generalises the fixed 8-bit/320-wide Gaussian stage in pixel width, image width, kernel mode and border handling, with fixed latency and coordinate passthrough.

Parameters:
- DATA_W, 8, pixel bit width.
- IMG_W, 320, active pixels per line (line-buffer depth).
- X_W, 9, x coordinate width; must satisfy 2^X_W >= IMG_W.
- Y_W, 8, y coordinate width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input pixel qualifier; pixels arrive in raster order, gaps allowed.
- in_sof  in  1  start of frame; high with the pixel at (0,0) only.
- in_x  in  X_W  column of in_pixel.
- in_y  in  Y_W  row of in_pixel.
- in_pixel  in  DATA_W  input grayscale sample.
- mode  in  2  kernel select: 0 bypass, 1 gaussian, 2 sharpen, 3 laplacian.
- out_valid  out  1  output qualifier.
- out_pixel  out  DATA_W  filtered sample.
- out_x  out  X_W  in_x delayed to align with out_pixel.
- out_y  out  Y_W  in_y delayed to align with out_pixel.

Behaviour:
- Reset: on any posedge clk with rst_n=0, out_valid=0, out_pixel=0, out_x=0, out_y=0, mode_q=1 (gaussian), ping-pong select=0, pipeline valid bits cleared.
  - Line-buffer RAM is not reset.
  - Reset mid-frame drops all in-flight pixels; normal output resumes at the next in_sof.
- Mode latch: mode is sampled into mode_q only on an in_valid & in_sof cycle. Mid-frame changes are ignored until the next frame.
- Window: for each accepted pixel (x,y), taps cover columns x-2..x and rows y-2..y.
  - Default borders replicate (clamp): column index <0 takes column 0; row index <0 takes row 0.
  - out_pixel is the result centred at (x-1,y-1), tagged with out_x=x, out_y=y.
- Line buffers: two IMG_W x DATA_W rows, read-before-write at address in_x.
  - The buffer holding row y-2 is overwritten with row y.
  - Select toggles on in_valid with in_x==0; it is forced to 0 on in_sof.
- Horizontal shift registers advance only when in_valid=1. With in_valid=0 the pipeline still advances and emits bubbles (no backpressure).
- Latency: exactly 4 cycles. out_valid(t+4) = in_valid(t).
  - S1: window/tap capture.
  - S2: weighted partial sums.
  - S3: final signed sum in a DATA_W+5-bit accumulator.
  - S4: normalise/saturate and register the output.
- When out_valid=0, out_pixel=0 and out_x/out_y hold their previous values.
- Arithmetic, with c = centre and e = the 4 edge neighbours:
  - Bypass: out = c.
  - Gaussian: (corners + 2*edges + 4*c) >> 4, truncating.
  - Sharpen: 5*c - sum(e), saturated to [0, 2^DATA_W-1].
  - Laplacian: |4*c - sum(e)|, saturated to 2^DATA_W-1.
- Boundary conditions:
  - in_x==IMG_W-1 followed by in_x==0 is the line wrap.
  - in_sof asserted without a prior end of frame restarts cleanly; no stale rows are used, because the y-clamp selects the current row for y<2.

Optional Feature:
- Macro: CONV3X3_BORDER_ZERO_EN.
- Defined: out-of-image taps read as 0 (zero padding) instead of replicated edge pixels.
- Undefined: replicate clamping as above.
- Latency and ports are identical in both builds.

Decomposition:
- Package conv3x3_pkg holds:
  - mode enum (MODE_BYPASS=0, MODE_GAUSS=1, MODE_SHARP=2, MODE_LAPL=3);
  - localparam CONV_LAT=4;
  - accumulator width function ACC_W(DATA_W)=DATA_W+5.
- One sub-module, conv3x3_linebuf: ping-pong two-row RAM with read-before-write, select toggling, and y-clamp row muxing. It outputs top/mid/cur column taps.
- Kernel arithmetic stays in the top module.

Test Plan:
- Flat 320x240 frame of 100, mode=1 -> every out_pixel=100, out_valid exactly 4 cycles after each in_valid, 76800 outputs.
- Zero frame with an impulse 255 at (5,5), mode=1 -> at tag (6,6) out=63; at tag (7,7) out=15; at tag (6,5) out=31; all other tags 0.
- Centre 255 among 0s, mode=2 -> tag (6,6) out=255 (1275 saturated). Centre 0 among 255s -> 0 (-1020 clamped).
- Flat 200 frame, mode=3 -> all 0. Vertical step 0|255 at x=10 -> tag (10,y) out=255 and tag (11,y) out=255 for y>=1.
- mode switched 1->2 mid-frame -> gaussian results until next in_sof, then sharpen. rst_n low for 1 cycle mid-line -> out_valid=0 next cycle, no output until the next in_sof pixel +4 cycles.
- Random in_valid gaps (50% duty) on a ramp frame -> output stream identical to the gapless run, with matching out_x/out_y.
